design_method_driver: RTL and testbench

//   Caller-side sequencer for a BSV-style method interface: start(a,b) action, result(c) value, check(d) actionvalue.

---
 rtl/design_method_driver.sv | 221 ++++++++++++++++++++++
 tb/tb_design_method_driver.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/design_method_driver.sv
// design_method_driver
//   Caller-side sequencer for a method-style DUT interface made of three
//   methods: start(a,b) is an action, result(c) returns a value and
//   check(d) is an actionvalue. Jobs are queued in a small FIFO. Each job
//   runs start -> result -> check under the RDY/EN rules. The check return
//   value is compared with the expected value of the job. One report is
//   produced per job, and saturating pass/fail counts are kept.
//
// Ports
//   clk_i, rst_ni               clock (rising edge), async active-low reset
//   job_valid_i / job_ready_o   upstream job handshake
//   job_a_i..job_d_i, job_exp_i job arguments and expected check return
//   start_a_o, start_b_o        start arguments
//   stenable_o, rdy_start_i     start enable / ready
//   result_c_o, result_i        result argument / return value
//   rdy_result_i                result ready
//   check_d_o, check_i          check argument / return value
//   chenable_o, rdy_check_i     check enable / ready
//   rpt_valid_o / rpt_ready_i   report handshake
//   rpt_result_o, rpt_pass_o,   captured result, pass flag, timeout flag
//   rpt_timeout_o
//   pass_cnt_o, fail_cnt_o      saturating job counts
module design_method_driver #(
  parameter int W       = 5,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         job_valid_i,
  output logic         job_ready_o,
  input  logic [W-1:0] job_a_i,
  input  logic [W-1:0] job_b_i,
  input  logic [W-1:0] job_c_i,
  input  logic [W-1:0] job_d_i,
  input  logic [W-1:0] job_exp_i,
  output logic [W-1:0] start_a_o,
  output logic [W-1:0] start_b_o,
  output logic         stenable_o,
  input  logic         rdy_start_i,
  output logic [W-1:0] result_c_o,
  input  logic [W-1:0] result_i,
  input  logic         rdy_result_i,
  output logic [W-1:0] check_d_o,
  input  logic [W-1:0] check_i,
  output logic         chenable_o,
  input  logic         rdy_check_i,
  output logic         rpt_valid_o,
  input  logic         rpt_ready_i,
  output logic [W-1:0] rpt_result_o,
  output logic         rpt_pass_o,
  output logic         rpt_timeout_o,
  output logic [15:0]  pass_cnt_o,
  output logic [15:0]  fail_cnt_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int JW = 5 * W;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_START    = 3'd1,
    ST_WAIT_RES = 3'd2,
    ST_CHECK    = 3'd3,
    ST_REPORT   = 3'd4
  } state_e;

  state_e          state_q;
  logic [JW-1:0]   mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic            push_s, pop_s;
  logic [W-1:0]    a_q, b_q, c_q, d_q, exp_q, res_q;
  logic [TW-1:0]   timer_q;
  logic            pass_q, timeout_q;
  logic [15:0]     pass_cnt_q, fail_cnt_q;

  // job_ready comes only from the registered count, so it never depends on a pop this cycle.
  assign job_ready_o = (count_q != CW'(DEPTH));
  assign push_s      = job_valid_i & job_ready_o;
  assign pop_s       = (state_q == ST_IDLE) && (count_q != CW'(0));

  // Next-state value of the FIFO occupancy.
  always_comb begin
    count_d = count_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO pointers and occupancy. DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_s) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_s)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
    end
  end

  // FIFO storage. The entries are qualified by the pointers and count, so they have no reset.
  always_ff @(posedge clk_i) begin
    if (push_s) mem_q[wr_ptr_q] <= {job_a_i, job_b_i, job_c_i, job_d_i, job_exp_i};
  end

  // Sequencer: the working registers, timer, report fields and counters.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= '0;
      d_q        <= '0;
      exp_q      <= '0;
      res_q      <= '0;
      timer_q    <= '0;
      pass_q     <= 1'b0;
      timeout_q  <= 1'b0;
      pass_cnt_q <= 16'd0;
      fail_cnt_q <= 16'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pop_s) begin
            {a_q, b_q, c_q, d_q, exp_q} <= mem_q[rd_ptr_q];
            // Clear the report fields so that a job that timed out reports a zero result.
            res_q     <= '0;
            pass_q    <= 1'b0;
            timeout_q <= 1'b0;
            timer_q   <= '0;
            state_q   <= ST_START;
          end
        end
        ST_START: begin
          if (rdy_start_i) begin
            timer_q <= '0;
            state_q <= ST_WAIT_RES;
          end
        end
        ST_WAIT_RES: begin
          if (rdy_result_i) begin
            res_q   <= result_i;
            timer_q <= '0;
            state_q <= ST_CHECK;
          end else if (timer_q == TW'(TIMEOUT - 1)) begin
            timeout_q <= 1'b1;
            pass_q    <= 1'b0;
            state_q   <= ST_REPORT;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        ST_CHECK: begin
          if (rdy_check_i) begin
            pass_q  <= (check_i == exp_q);
            state_q <= ST_REPORT;
          end else if (timer_q == TW'(TIMEOUT - 1)) begin
            timeout_q <= 1'b1;
            pass_q    <= 1'b0;
            state_q   <= ST_REPORT;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        ST_REPORT: begin
          if (rpt_ready_i) begin
            if (pass_q) begin
              if (pass_cnt_q != 16'hFFFF) pass_cnt_q <= pass_cnt_q + 16'd1;
            end else begin
              if (fail_cnt_q != 16'hFFFF) fail_cnt_q <= fail_cnt_q + 16'd1;
            end
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // DUT-facing signals are decoded from the registered state. They are zero
  // outside their owning state, and they drop at once when reset is asserted.
  always_comb begin
    start_a_o   = '0;
    start_b_o   = '0;
    stenable_o  = 1'b0;
    result_c_o  = '0;
    check_d_o   = '0;
    chenable_o  = 1'b0;
    rpt_valid_o = 1'b0;
    case (state_q)
      ST_START: begin
        start_a_o  = a_q;
        start_b_o  = b_q;
        stenable_o = rdy_start_i;
      end
      ST_WAIT_RES: result_c_o = c_q;
      ST_CHECK: begin
        check_d_o  = d_q;
        chenable_o = rdy_check_i;
      end
      ST_REPORT: rpt_valid_o = 1'b1;
      default: begin
        start_a_o = '0;
      end
    endcase
  end

  assign rpt_result_o  = res_q;
  assign rpt_pass_o    = pass_q;
  assign rpt_timeout_o = timeout_q;
  assign pass_cnt_o    = pass_cnt_q;
  assign fail_cnt_o    = fail_cnt_q;

endmodule

// File: tb/tb_design_method_driver.sv
// Directed bench for design_method_driver.
// The bench drives inputs 1 time unit after each rising edge and samples
// outputs 1 time unit later. Cycle numbers count from the cycle in which
// job_valid is accepted.
module tb_design_method_driver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        job_valid;
  logic        job_ready;
  logic [4:0]  job_a, job_b, job_c, job_d, job_exp;
  logic [4:0]  start_a, start_b, result_c, check_d, result_v, check_v, rpt_result;
  logic        stenable, chenable, rdy_start, rdy_result, rdy_check;
  logic        rpt_valid, rpt_ready, rpt_pass, rpt_timeout;
  logic [15:0] pass_cnt, fail_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // The modelled DUT returns c+10 from result(c).
  assign result_v = result_c + 5'd10;

  design_method_driver dut (
    .clk_i(clk), .rst_ni(rst_n),
    .job_valid_i(job_valid), .job_ready_o(job_ready),
    .job_a_i(job_a), .job_b_i(job_b), .job_c_i(job_c), .job_d_i(job_d), .job_exp_i(job_exp),
    .start_a_o(start_a), .start_b_o(start_b), .stenable_o(stenable), .rdy_start_i(rdy_start),
    .result_c_o(result_c), .result_i(result_v), .rdy_result_i(rdy_result),
    .check_d_o(check_d), .check_i(check_v), .chenable_o(chenable), .rdy_check_i(rdy_check),
    .rpt_valid_o(rpt_valid), .rpt_ready_i(rpt_ready), .rpt_result_o(rpt_result),
    .rpt_pass_o(rpt_pass), .rpt_timeout_o(rpt_timeout),
    .pass_cnt_o(pass_cnt), .fail_cnt_o(fail_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut;
    rst_n = 1'b0; job_valid = 1'b0;
    rdy_start = 1'b1; rdy_result = 1'b1; rdy_check = 1'b1; rpt_ready = 1'b1;
    check_v = 5'd7;
    job_a = 5'd0; job_b = 5'd0; job_c = 5'd0; job_d = 5'd0; job_exp = 5'd0;
    tick;
    tick;
    rst_n = 1'b1;
  endtask

  // Job a=3,b=4,c=1,d=2,exp=7, all RDY high. The bench checks each cycle from 0 to 6.
  task automatic run_job(input logic [4:0] ret, input logic exp_pass);
    job_a = 5'd3; job_b = 5'd4; job_c = 5'd1; job_d = 5'd2; job_exp = 5'd7;
    check_v = ret; job_valid = 1'b1;
    #1;
    chk("c0_job_ready", job_ready, 1);
    chk("c0_stenable", stenable, 0);
    tick; job_valid = 1'b0; #1;
    chk("c1_stenable", stenable, 0);
    tick; #1;
    chk("c2_stenable", stenable, 1);
    chk("c2_start_a", start_a, 3);
    chk("c2_start_b", start_b, 4);
    chk("c2_result_c", result_c, 0);
    tick; #1;
    chk("c3_stenable", stenable, 0);
    chk("c3_result_c", result_c, 1);
    chk("c3_start_a", start_a, 0);
    chk("c3_chenable", chenable, 0);
    tick; #1;
    chk("c4_chenable", chenable, 1);
    chk("c4_check_d", check_d, 2);
    chk("c4_result_c", result_c, 0);
    tick; #1;
    chk("c5_rpt_valid", rpt_valid, 1);
    chk("c5_rpt_pass", rpt_pass, exp_pass);
    chk("c5_rpt_timeout", rpt_timeout, 0);
    chk("c5_rpt_result", rpt_result, 11);
    chk("c5_chenable", chenable, 0);
    chk("c5_check_d", check_d, 0);
    tick; #1;
    chk("c6_rpt_valid", rpt_valid, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int waited;
    rst_n = 1'b1; job_valid = 1'b0;
    rdy_start = 1'b1; rdy_result = 1'b1; rdy_check = 1'b1; rpt_ready = 1'b1;
    check_v = 5'd7;
    job_a = 5'd0; job_b = 5'd0; job_c = 5'd0; job_d = 5'd0; job_exp = 5'd0;
    #1 rst_n = 1'b0;
    #1;
    // Reset state
    chk("rst_job_ready", job_ready, 1);
    chk("rst_rpt_valid", rpt_valid, 0);
    chk("rst_stenable", stenable, 0);
    chk("rst_chenable", chenable, 0);
    chk("rst_pass_cnt", pass_cnt, 0);
    chk("rst_fail_cnt", fail_cnt, 0);
    chk("rst_rpt_pass", rpt_pass, 0);

    // Test 1: a passing job
    reset_dut;
    run_job(5'd7, 1'b1);
    chk("t1_pass_cnt", pass_cnt, 1);
    chk("t1_fail_cnt", fail_cnt, 0);

    // Test 2: a failing check
    reset_dut;
    run_job(5'd6, 1'b0);
    chk("t2_pass_cnt", pass_cnt, 0);
    chk("t2_fail_cnt", fail_cnt, 1);

    // Test 3: RDY_start low for 10 cycles
    reset_dut;
    rdy_start = 1'b0; check_v = 5'd7;
    job_a = 5'd3; job_b = 5'd4; job_c = 5'd1; job_d = 5'd2; job_exp = 5'd7; job_valid = 1'b1;
    tick; job_valid = 1'b0;
    for (int i = 0; i < 11; i++) begin
      #1; chk("t3_stenable_wait", stenable, 0);
      tick;
    end
    rdy_start = 1'b1; #1;
    chk("t3_stenable_fire", stenable, 1);
    chk("t3_start_a", start_a, 3);
    tick; #1;
    chk("t3_stenable_after", stenable, 0);
    chk("t3_result_c", result_c, 1);
    tick; #1;
    chk("t3_chenable", chenable, 1);
    tick; #1;
    chk("t3_rpt_valid", rpt_valid, 1);
    chk("t3_rpt_timeout", rpt_timeout, 0);
    chk("t3_rpt_pass", rpt_pass, 1);
    tick; #1;
    chk("t3_pass_cnt", pass_cnt, 1);

    // Test 4: RDY_result never asserted, so the job times out in WAIT_RES
    reset_dut;
    rdy_result = 1'b0;
    job_a = 5'd3; job_b = 5'd4; job_c = 5'd1; job_d = 5'd2; job_exp = 5'd7; job_valid = 1'b1;
    tick; job_valid = 1'b0;
    tick; #1;
    chk("t4_stenable", stenable, 1);
    for (int i = 0; i < 15; i++) begin
      tick; #1;
      chk("t4_rpt_valid_wait", rpt_valid, 0);
      chk("t4_chenable_wait", chenable, 0);
    end
    tick; #1;
    chk("t4_rpt_valid", rpt_valid, 1);
    chk("t4_rpt_timeout", rpt_timeout, 1);
    chk("t4_rpt_pass", rpt_pass, 0);
    chk("t4_rpt_result", rpt_result, 0);
    chk("t4_chenable", chenable, 0);
    tick; #1;
    chk("t4_fail_cnt", fail_cnt, 1);
    chk("t4_pass_cnt", pass_cnt, 0);

    // Test 5: capacity and report order with rpt_ready held low
    reset_dut;
    rpt_ready = 1'b0; check_v = 5'd7;
    acc = 0;
    for (int k = 0; k < 8; k++) begin
      job_valid = 1'b1;
      job_a = 5'(acc); job_b = 5'(acc); job_d = 5'(acc); job_c = 5'(acc + 1);
      job_exp = ((acc % 2) == 0) ? 5'd7 : 5'd3;
      #1;
      if (job_ready) acc++;
      tick;
    end
    job_valid = 1'b0; #1;
    chk("t5_accepted", acc, 5);
    chk("t5_job_ready", job_ready, 0);
    chk("t5_rpt_valid_held", rpt_valid, 1);
    chk("t5_pass_cnt_held", pass_cnt, 0);
    rpt_ready = 1'b1; #1;
    for (int j = 0; j < 5; j++) begin
      waited = 0;
      while (!rpt_valid && waited < 20) begin
        tick; #1;
        waited++;
      end
      chk("t5_rpt_seen", rpt_valid, 1);
      chk("t5_rpt_result", rpt_result, j + 11);
      chk("t5_rpt_pass", rpt_pass, ((j % 2) == 0) ? 1 : 0);
      tick; #1;
    end
    chk("t5_pass_cnt", pass_cnt, 3);
    chk("t5_fail_cnt", fail_cnt, 2);
    chk("t5_job_ready_end", job_ready, 1);

    // Test 6: reset asserted in the middle of CHECK
    reset_dut;
    run_job(5'd7, 1'b1);
    chk("t6_pre_pass_cnt", pass_cnt, 1);
    tick;
    job_a = 5'd3; job_b = 5'd4; job_c = 5'd1; job_d = 5'd2; job_exp = 5'd7; job_valid = 1'b1;
    tick;
    tick; job_valid = 1'b0;
    tick;
    tick; #1;
    chk("t6_chenable_before", chenable, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_chenable_rst", chenable, 0);
    chk("t6_rpt_valid_rst", rpt_valid, 0);
    chk("t6_pass_cnt_rst", pass_cnt, 0);
    chk("t6_fail_cnt_rst", fail_cnt, 0);
    chk("t6_job_ready_rst", job_ready, 1);
    tick;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick; #1;
      chk("t6_no_stale_start", stenable, 0);
    end
    run_job(5'd7, 1'b1);
    chk("t6_post_pass_cnt", pass_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
